// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq: byte-serial AND/XOR/SHL1/ADD sequencer over a shared 8-bit ALU |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [2:0]          op_i,
    input  logic [8*NBYTES-1:0] a_i,
    input  logic [8*NBYTES-1:0] b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [8*NBYTES-1:0] result_o,
    output logic                carry_o,
    output logic                zf_o,
    output logic                err_o,
    output logic [2:0]          alu_op_o,
    output logic [7:0]          alu_r1_o,
    output logic [7:0]          alu_r2_o,
    input  logic [7:0]          alu_out_i,
    input  logic [1:0]          alu_ovf_i
);

    localparam int         W       = 8 * NBYTES;
    localparam int         IW      = $clog2(NBYTES);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SHL1 = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
    logic [2:0]      op_q, op_d;
    logic [IW-1:0]   i_q, i_d;
    logic            c_q, c_d, h_q, h_d;
    logic            carry_q, carry_d, zf_q, zf_d, err_q, err_d, done_q, done_d;
    logic [7:0]      a_byte, a_prev, b_byte, r_byte;
    logic            unused_ovf;

    assign unused_ovf = alu_ovf_i[1];

    function automatic logic legal_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_XOR) || (op == OP_SHL1) || (op == OP_ADD);
    endfunction

    always_comb begin
        a_byte = 8'h00;
        a_prev = 8'h00;
        b_byte = 8'h00;
        r_byte = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (int'(i_q) == k) begin
                a_byte = a_q[8*k +: 8];
                b_byte = b_q[8*k +: 8];
                r_byte = res_q[8*k +: 8];
            end
        end
        // SHL1 pulls the MSB of the byte below; byte 0 shifts in a zero
        for (int k = 1; k < NBYTES; k++) begin
            if (int'(i_q) == k) a_prev = a_q[8*(k-1) +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        i_d      = i_q;
        c_d      = c_q;
        h_d      = h_q;
        res_d    = res_q;
        result_d = result_q;
        carry_d  = carry_q;
        zf_d     = zf_q;
        err_d    = err_q;
        done_d   = 1'b0;
        alu_op_o = 3'b000;
        alu_r1_o = 8'h00;
        alu_r2_o = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    op_d    = op_i;
                    i_d     = '0;
                    c_d     = 1'b0;
                    h_d     = 1'b0;
                    res_d   = '0;
                    state_d = legal_op(op_i) ? S_RUN : S_DONE;
                end
            end
            S_RUN, S_FIX: begin
                if (state_q == S_FIX) begin
                    alu_op_o = OP_ADD;
                    alu_r1_o = r_byte;
                    alu_r2_o = 8'h01;
                end else begin
                    alu_op_o = op_q;
                    alu_r1_o = (op_q == OP_SHL1) ? a_prev : a_byte;
                    alu_r2_o = (op_q == OP_SHL1) ? a_byte : b_byte;
                end
                for (int k = 0; k < NBYTES; k++) begin
                    if (int'(i_q) == k) res_d[8*k +: 8] = alu_out_i;
                end
                // A pending carry is added in FIX before the byte index moves on
                if (state_q == S_RUN && op_q == OP_ADD && c_q) begin
                    h_d     = alu_ovf_i[0];
                    state_d = S_FIX;
                end else begin
                    if (state_q == S_FIX)
                        c_d = h_q | alu_ovf_i[0];
                    else if (op_q == OP_ADD)
                        c_d = alu_ovf_i[0];
                    if (int'(i_q) == NBYTES - 1) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + IW'(1);
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = res_q;
                zf_d     = (res_q == '0);
                err_d    = !legal_op(op_q);
                if (op_q == OP_ADD)
                    carry_d = c_q;
                else if (op_q == OP_SHL1)
                    carry_d = a_q[W-1];
                else
                    carry_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            i_q      <= '0;
            c_q      <= 1'b0;
            h_q      <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zf_q     <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            i_q      <= i_d;
            c_q      <= c_d;
            h_q      <= h_d;
            res_q    <= res_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zf_q     <= zf_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign zf_o     = zf_q;
    assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_seq: vector table + scoreboard bench for alu_seq (NBYTES=4)    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_seq;

    localparam int         NB      = 4;
    localparam int         W       = 8 * NB;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SHL1 = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b100;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, carry, zf, err;
    logic [W-1:0] result;
    logic [2:0]   alu_op;
    logic [7:0]   alu_r1, alu_r2, alu_out;
    logic [1:0]   alu_ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cy;
        logic         zf;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    alu_seq #(.NBYTES(NB)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .op_i      (op),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result),
        .carry_o   (carry),
        .zf_o      (zf),
        .err_o     (err),
        .alu_op_o  (alu_op),
        .alu_r1_o  (alu_r1),
        .alu_r2_o  (alu_r2),
        .alu_out_i (alu_out),
        .alu_ovf_i (alu_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model of the shared 8-bit ALU
    always_comb begin
        logic [8:0] sum;
        sum     = {1'b0, alu_r1} + {1'b0, alu_r2};
        alu_out = 8'h00;
        alu_ovf = 2'b00;
        case (alu_op)
            3'b000: alu_out = alu_r1 & alu_r2;
            3'b001: alu_out = alu_r1 ^ alu_r2;
            3'b010: alu_out = {alu_r2[6:0], alu_r1[7]};
            3'b100: begin
                alu_out    = sum[7:0];
                alu_ovf[0] = sum[8];
            end
            default: alu_out = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [W-1:0] r, input logic c, input logic z,
                                input logic e, input int l);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.res = r; v.cy = c; v.zf = z; v.err = e; v.lat = l;
        return v;
    endfunction

    task automatic run(input vec_t v, input bit poke);
        int   cnt;
        vec_t e;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        sb.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        cnt = 0;
        while (cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            if (done) break;
            if (poke && cnt == 2) begin
                start = 1'b1; op = OP_AND; a = '0; b = '0;
            end
            if (poke && cnt == 3) start = 1'b0;
        end
        e = sb.pop_front();
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: op=%0b no done within %0d cycles", e.op, cnt);
        end else begin
            check("latency", 64'(cnt), 64'(e.lat));
            check("result",  64'(result), 64'(e.res));
            check("carry",   64'(carry), 64'(e.cy));
            check("zf",      64'(zf), 64'(e.zf));
            check("err",     64'(err), 64'(e.err));
        end
        @(posedge clk);
        #1;
        check("done_pulse",  64'(done), 64'd0);
        check("result_hold", 64'(result), 64'(e.res));
        check("busy_idle",   64'(busy), 64'd0);
        check("alu_idle",    64'({alu_op, alu_r1, alu_r2}), 64'd0);
    endtask

    initial begin
        vecs.push_back(mk(OP_ADD,  32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, 6));
        vecs.push_back(mk(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 8));
        vecs.push_back(mk(OP_XOR,  32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 1'b0, 1'b1, 1'b0, 5));
        vecs.push_back(mk(3'b011,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 1'b1, 1));
        vecs.push_back(mk(OP_ADD,  32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0, 5));
        vecs.push_back(mk(OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 5));
        vecs.push_back(mk(OP_ADD,  32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0, 1'b0, 7));
        vecs.push_back(mk(OP_ADD,  32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 7));
        vecs.push_back(mk(OP_AND,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5));
        vecs.push_back(mk(3'b111,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 1));
        vecs.push_back(mk(OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0, 5));
        vecs.push_back(mk(OP_SHL1, 32'h40000001, 32'hFFFFFFFF, 32'h80000002, 1'b0, 1'b0, 1'b0, 5));
        vecs.push_back(mk(3'b101,  32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1, 1));
        vecs.push_back(mk(OP_SHL1, 32'h80808080, 32'h00000000, 32'h01010100, 1'b1, 1'b0, 1'b0, 5));

        #12;
        check("rst_outputs", 64'({busy, done, carry, zf, err}), 64'd0);
        check("rst_result",  64'(result), 64'd0);
        check("rst_alu",     64'({alu_op, alu_r1, alu_r2}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) run(vecs[k], 1'b0);

        // START pulsed while busy must not disturb an ADD in flight
        run(mk(OP_ADD, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, 6), 1'b1);
        run(mk(OP_SHL1, 32'h80808080, 32'h00000000, 32'h01010100, 1'b1, 1'b0, 1'b0, 5), 1'b0);

        // Asynchronous reset in the 3rd cycle of an ADD
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 32'hFFFFFFFF; b = 32'h00000001;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_flags",  64'({busy, done, carry, zf, err}), 64'd0);
        check("async_rst_result", 64'(result), 64'd0);
        check("async_rst_alu",    64'({alu_op, alu_r1, alu_r2}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(mk(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 5), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter NBYTES, default 4: operand width in bytes; supported values are 2 to 8.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 START  input  1  request; sampled only in IDLE.
REQ-005 OP  input  3  operation: 000 AND, 001 XOR, 010 SHL1 (A shifted left 1 bit), 100 ADD; every other code is illegal.
REQ-006 A  input  8*NBYTES  first operand.
REQ-007 B  input  8*NBYTES  second operand; ignored for SHL1.
REQ-008 BUSY  output  1  high in every non-IDLE state.
REQ-009 DONE  output  1  single-cycle pulse; RESULT, CARRY, ZF and ERR are valid in this cycle.
REQ-010 RESULT  output  8*NBYTES  operation result; held until the next DONE.
REQ-011 CARRY  output  1  ADD: carry out of the top byte; SHL1: bit shifted out of A's MSB; AND/XOR: 0.
REQ-012 ZF  output  1  1 when RESULT equals 0.
REQ-013 ERR  output  1  1 when the request used an illegal OP.
REQ-014 ALU_OP  output  3  operation code driven to the shared 8-bit ALU.
REQ-015 ALU_R1  output  8  ALU first operand.
REQ-016 ALU_R2  output  8  ALU second operand.
REQ-017 ALU_OUT  input  8  ALU result; combinational from ALU_OP, ALU_R1 and ALU_R2.
REQ-018 ALU_OVF  input  2  ALU overflow; bit 0 is the carry out of bit 7 for OP 100.

Function
REQ-019 The FSM shall have states IDLE, RUN, FIX and DONE.
REQ-020 In IDLE with START=1, the block shall latch A, B and OP, clear the byte index i and the carry register c, and go to RUN; an illegal OP shall go directly to DONE.
REQ-021 RUN byte i shall drive the ALU as follows:
- AND/XOR: OP = 000/001, R1 = A[i], R2 = B[i].
- SHL1: OP = 010, R1 = A[i-1] (8'h00 when i=0), R2 = A[i].
- ADD: OP = 100, R1 = A[i], R2 = B[i].
REQ-022 At each RUN edge, the block shall write ALU_OUT into result byte i.
REQ-023 For ADD, a RUN edge with c=1 shall go to FIX without advancing i; otherwise c shall take ALU_OVF[0].
REQ-024 FIX shall drive OP=100, R1=result byte i, R2=8'h01, and write ALU_OUT into result byte i.
REQ-025 On leaving FIX, c shall become (RUN-pass ALU_OVF[0] held in a register) OR (FIX-pass ALU_OVF[0]).
REQ-026 After the last byte (RUN or FIX), the FSM shall enter DONE; otherwise it shall return to RUN with i+1.
REQ-027 DONE shall last exactly one cycle and then return to IDLE; a START held high in that IDLE cycle shall start a new operation.
REQ-028 Latency shall be measured from the START-sampling edge to the edge that raises DONE:
- AND/XOR/SHL1: NBYTES+1 cycles.
- ADD: NBYTES+1 plus one cycle per byte with incoming carry.
- Illegal OP: 1 cycle.
REQ-029 For an illegal OP, DONE shall present RESULT=0, CARRY=0, ZF=1 and ERR=1.
REQ-030 START outside IDLE shall be ignored; latched operands shall not change until IDLE.
REQ-031 Outside RUN and FIX, the ALU_* outputs shall be driven to 0.

Reset
REQ-032 RESET_N=0 shall immediately force IDLE and set BUSY=0, DONE=0, RESULT=0, CARRY=0, ZF=0, ERR=0, ALU_OP=0, ALU_R1=0, ALU_R2=0, i=0 and c=0, including in the middle of an operation.
REQ-033 After RESET_N deasserts, the first START shall be accepted on the first rising edge that samples it in IDLE.

Verification
REQ-034 ADD, A=32'h000000FF, B=32'h00000001 -> RESULT=32'h00000100, CARRY=0, ZF=0, DONE 6 cycles after START, with one FIX at byte 1.
REQ-035 ADD, A=32'hFFFFFFFF, B=32'h00000001 -> RESULT=0, CARRY=1, ZF=1, DONE after 8 cycles.
REQ-036 SHL1, A=32'h80808080 -> RESULT=32'h01010100, CARRY=1, DONE after 5 cycles; XOR with A=B=32'h5A5A5A5A -> RESULT=0, ZF=1.
REQ-037 OP=011 -> DONE after 1 cycle with ERR=1 and RESULT=0; a START pulsed during BUSY of an ADD shall not change RESULT or timing.
REQ-038 RESET_N low in the 3rd cycle of an ADD -> all outputs 0 with no clock edge; a subsequent AND of 32'hF0F0F0F0 and 32'hFF00FF00 -> RESULT=32'hF000F000.
